// File: rtl/voice_allocator.sv
// Three-voice note allocator: accepts note requests, loads the lowest free note player one
// cycle later, and tracks busy flags and voice age. Define VOICE_STEAL_EN to steal the oldest voice when all are busy.
module voice_allocator #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [NOTE_W-1:0] req_note,
    input  logic [DUR_W-1:0]  req_duration,
    input  logic [2:0]        note_done,
    output logic [2:0]        load,
    output logic [NOTE_W-1:0] load_note,
    output logic [DUR_W-1:0]  load_duration,
    output logic [2:0]        voice_busy,
    output logic [7:0]        stall_count
);

`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [1:0]        rank      [3];
    logic [1:0]        rank_next [3];
    logic [1:0]        old_rank;
    logic [2:0]        busy_next;
    logic [2:0]        sel_voice;
    logic [2:0]        pend_voice;
    logic [2:0]        protect;
    logic [NOTE_W-1:0] pend_note;
    logic [DUR_W-1:0]  pend_duration;
    logic              load_pending;
    logic              all_busy;
    logic              accept;
    logic              steal_accept;

    // The LOADING state is exactly the window between accept and the load pulse.
    assign load_pending  = (state == LOADING);
    assign all_busy      = &voice_busy;
    assign req_ready     = ~reset & play & ~flush & (~all_busy | STEAL) & ~load_pending;
    assign accept        = req_valid & req_ready;
    assign steal_accept  = accept & all_busy;
    assign load          = (load_pending & ~flush) ? pend_voice : 3'b000;
    assign load_note     = pend_note;
    assign load_duration = pend_duration;

    always_comb begin
        sel_voice = '0;
        if (!voice_busy[0]) begin
            sel_voice = 3'b001;
        end else if (!voice_busy[1]) begin
            sel_voice = 3'b010;
        end else if (!voice_busy[2]) begin
            sel_voice = 3'b100;
        end
`ifdef VOICE_STEAL_EN
        else begin
            for (int unsigned v = 0; v < 3; v++) begin
                if (rank[v] == 2'd2) begin
                    sel_voice[v] = 1'b1;
                end
            end
        end
`endif
    end

    // A stolen voice must not drop its busy flag on a same-cycle note_done.
    always_comb begin
        protect   = steal_accept ? sel_voice : 3'b000;
        busy_next = (voice_busy & ~(note_done & ~protect)) | load;
        if (flush) begin
            busy_next = '0;
        end
    end

    always_comb begin
        old_rank  = '0;
        rank_next = rank;
        for (int unsigned v = 0; v < 3; v++) begin
            if (load[v]) begin
                old_rank = rank[v];
            end
        end
        if (|load) begin
            for (int unsigned v = 0; v < 3; v++) begin
                if (load[v]) begin
                    rank_next[v] = 2'd0;
                end else if (rank[v] < old_rank) begin
                    rank_next[v] = rank[v] + 2'd1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LOADING;
                end
            end
            LOADING: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (&busy_next) begin
                    state_next = FULL;
                end else begin
                    state_next = IDLE;
                end
            end
            FULL: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (accept) begin
                    state_next = LOADING;
                end else if (|note_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            voice_busy    <= '0;
            pend_voice    <= '0;
            pend_note     <= '0;
            pend_duration <= '0;
            stall_count   <= '0;
            rank[0]       <= 2'd2;
            rank[1]       <= 2'd1;
            rank[2]       <= 2'd0;
        end else begin
            state      <= state_next;
            voice_busy <= busy_next;
            rank       <= rank_next;
            if (accept) begin
                pend_voice    <= sel_voice;
                pend_note     <= req_note;
                pend_duration <= req_duration;
            end
            if (req_valid && !req_ready && stall_count != 8'hFF) begin
                stall_count <= stall_count + 8'd1;
            end
        end
    end

endmodule
